// File: rtl/keyboard_line_buffer.sv
// Line editor: collects printable characters with backspace editing, then on
// Enter streams the stored line out over valid/ready, terminated by 0x0D.
module keyboard_line_buffer #(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_aclr_n,
  input  logic          i_char_en,
  input  logic [7:0]    i_char,
  input  logic          i_rdy,
  output logic          o_valid,
  output logic [7:0]    o_byte,
  output logic          o_last,
  output logic [AW:0]   o_len,
  output logic          o_busy,
  output logic          o_ovf,
  output logic          dbg_state
);

  // Handshake: a byte moves when o_valid & i_rdy at a rising edge; while
  // o_valid is high and i_rdy is low, o_byte and o_last hold their values.

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [7:0]  CH_BS   = 8'h08;
  localparam logic [7:0]  CH_CR   = 8'h0D;

  state_t       state;
  logic [AW:0]  len;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  nxt_ptr;
  logic [7:0]   mem [DEPTH];
  logic         printable;
  logic         wr_en;
  logic         xfer;

  assign printable = (i_char >= 8'h20) && (i_char <= 8'h7E);
  assign wr_en     = (state == FILL) && i_char_en && printable && (len < DEPTH_L);
  assign xfer      = o_valid && i_rdy;
  assign nxt_ptr   = rd_ptr + (AW+1)'(1);

  assign o_len     = len;
  assign o_busy    = (state == DRAIN);
  assign dbg_state = state;

  // Storage is deliberately left unreset; only len decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[len[AW-1:0]] <= i_char;
  end

  always_ff @(posedge clk or negedge i_aclr_n) begin
    if (!i_aclr_n) begin
      state   <= FILL;
      len     <= '0;
      rd_ptr  <= '0;
      o_valid <= 1'b0;
      o_byte  <= 8'h00;
      o_last  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (i_char_en) begin
            if (printable) begin
              if (len < DEPTH_L) len <= len + (AW+1)'(1);
              else               o_ovf <= 1'b1;
            end else if (i_char == CH_BS) begin
              if (len != '0) len <= len - (AW+1)'(1);
            end else if (i_char == CH_CR) begin
              state   <= DRAIN;
              rd_ptr  <= '0;
              o_valid <= 1'b1;
              if (len != '0) begin
                o_byte <= mem[0];
                o_last <= 1'b0;
              end else begin
                o_byte <= CH_CR;
                o_last <= 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (i_char_en) o_ovf <= 1'b1;
          if (xfer) begin
            if (o_last) begin
              state   <= FILL;
              len     <= '0;
              rd_ptr  <= '0;
              o_valid <= 1'b0;
              o_last  <= 1'b0;
            end else begin
              rd_ptr <= nxt_ptr;
              if (nxt_ptr < len) begin
                o_byte <= mem[nxt_ptr[AW-1:0]];
              end else begin
                o_byte <= CH_CR;
                o_last <= 1'b1;
              end
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
